uart_alu_ctrl: RTL

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

---
 rtl/uart_alu_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_ctrl
//
// Purpose:
//   Sequencer that sits between a byte-oriented UART and a combinational ALU.
//   It collects three received bytes (operand A, operand B, opcode). It
//   presents them to the ALU and lets the result settle for one cycle. It then
//   captures the result, strobes the transmitter once, and waits for the
//   transmitter to finish before accepting the next operand A.
//
// Optional feature:
//   `define UART_ALU_CTRL_TIMEOUT_EN enables an inter-byte timeout. While the
//   controller waits for operand B or the opcode, a counter runs. If no byte
//   arrives within TIMEOUT_CYCLES clocks, the controller abandons the
//   transaction and pulses o_error. When the macro is undefined there is no
//   counter, the controller waits forever, and o_error is tied low.
//
// Parameters:
//   DATA_WIDTH      width of UART bytes, operands and result
//   OP_WIDTH        width of the ALU opcode (low bits of the op byte)
//   TIMEOUT_CYCLES  inter-byte timeout in clocks (timeout build only)
//
// Ports:
//   i_clock         rising-edge system clock
//   i_reset         synchronous active-high reset
//   i_rx_done       one-cycle pulse: new byte on i_rx_data
//   i_rx_data       received byte
//   i_tx_done       one-cycle pulse: transmitter finished its stop bit
//   i_alu_result    combinational ALU result for o_alu_a/o_alu_b/o_alu_op
//   o_alu_a         registered operand A
//   o_alu_b         registered operand B
//   o_alu_op        registered opcode
//   o_tx_data_byte  registered byte presented to the transmitter
//   o_tx_signal     one-cycle transmit-start strobe
//   o_busy          high in every state except RX_A
//   o_error         one-cycle pulse on inter-byte timeout
// -----------------------------------------------------------------------------
module uart_alu_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_tx_done,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic [DATA_WIDTH-1:0] o_tx_data_byte,
  output logic                  o_tx_signal,
  output logic                  o_busy,
  output logic                  o_error
);

  localparam logic [2:0] RX_A    = 3'd0;
  localparam logic [2:0] RX_B    = 3'd1;
  localparam logic [2:0] RX_OP   = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;

  logic [2:0]            state_reg,     state_next;
  logic [DATA_WIDTH-1:0] alu_a_reg,     alu_a_next;
  logic [DATA_WIDTH-1:0] alu_b_reg,     alu_b_next;
  logic [OP_WIDTH-1:0]   alu_op_reg,    alu_op_next;
  logic [DATA_WIDTH-1:0] tx_data_reg,   tx_data_next;
  logic                  tx_signal_reg, tx_signal_next;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg, count_next;
  logic             error_reg, error_next;
  logic             timeout_hit;

  assign timeout_hit = (count_reg == CNT_LAST);

  // The counter only runs while waiting for B or the opcode. It restarts from
  // zero on every accepted byte. It also starts from zero on entry to RX_B,
  // because every other state leaves it at zero.
  always_comb begin
    count_next = '0;
    if ((state_reg == RX_B || state_reg == RX_OP) && !i_rx_done && !timeout_hit)
      count_next = count_reg + CNT_W'(1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      error_reg <= error_next;
    end
  end

  assign o_error = error_reg;
`else
  // The timeout depth has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign o_error = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    alu_op_next    = alu_op_reg;
    tx_data_next   = tx_data_reg;
    tx_signal_next = 1'b0;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    error_next     = 1'b0;
`endif
    case (state_reg)
      RX_A: begin
        if (i_rx_done) begin
          alu_a_next = i_rx_data;
          state_next = RX_B;
        end
      end
      RX_B: begin
        if (i_rx_done) begin
          alu_b_next = i_rx_data;
          state_next = RX_OP;
        end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = RX_A;
          error_next = 1'b1;
        end
`endif
      end
      RX_OP: begin
        if (i_rx_done) begin
          // Only the low opcode bits matter; the rest of the byte is discarded.
          alu_op_next = i_rx_data[OP_WIDTH-1:0];
          state_next  = EXEC;
        end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = RX_A;
          error_next = 1'b1;
        end
`endif
      end
      EXEC: begin
        // The operands have been stable for a full cycle. The ALU output is
        // settled, so capture it. Raising the strobe here makes it high
        // during SEND.
        tx_data_next   = i_alu_result;
        tx_signal_next = 1'b1;
        state_next     = SEND;
      end
      SEND: begin
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        // A byte arriving here is dropped, even when it coincides with
        // i_tx_done.
        if (i_tx_done)
          state_next = RX_A;
      end
      default: begin
        state_next = RX_A;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg     <= RX_A;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_op_reg    <= '0;
      tx_data_reg   <= '0;
      tx_signal_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      alu_op_reg    <= alu_op_next;
      tx_data_reg   <= tx_data_next;
      tx_signal_reg <= tx_signal_next;
    end
  end

  assign o_alu_a        = alu_a_reg;
  assign o_alu_b        = alu_b_reg;
  assign o_alu_op       = alu_op_reg;
  assign o_tx_data_byte = tx_data_reg;
  assign o_tx_signal    = tx_signal_reg;
  assign o_busy         = (state_reg != RX_A);

endmodule
